// File: rtl/ripple_window_ctrl.sv
// Gated event counter sequencer for an external 4-bit asynchronous ripple counter.
// Optional macro RIPPLE_CHECK_EN adds an err output comparing the capture against a shadow count.
module ripple_window_ctrl #(
    parameter int N      = 4,
    parameter int WIN_W  = 16,
    parameter int SETTLE = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIN_W-1:0] win_len,
    input  logic             ev,
    input  logic [N-1:0]     rc_q,
    output logic             rc_tick,
    output logic             rc_clr,
    output logic             busy,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [N-1:0]     result,
    output logic             ovf
`ifdef RIPPLE_CHECK_EN
    ,
    output logic             err
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_RUN,
        S_SETTLE,
        S_CAPTURE,
        S_HOLD
    } state_t;

    localparam logic [WIN_W-1:0] SETTLE_LOAD = WIN_W'(SETTLE);

    state_t           state_reg, state_next;
    logic [WIN_W-1:0] win_cnt_reg, win_cnt_next;
    logic             rc_tick_reg, rc_tick_next;
    logic             rc_clr_reg, rc_clr_next;
    logic             res_valid_reg, res_valid_next;
    logic [N-1:0]     result_reg, result_next;
    logic             ovf_reg, ovf_next;

`ifdef RIPPLE_CHECK_EN
    // Full shadow count, saturating at 2^N so the overflow bit is sticky.
    localparam logic [N:0] SHADOW_SAT = {1'b1, {N{1'b0}}};
    logic [N:0] shadow_reg, shadow_next;
    logic       err_reg, err_next;
`else
    // Low bits wrap like the ripple counter; only the overflow flag matters.
    logic [N-1:0] tick_lo_reg, tick_lo_next;
    logic         ovf_flag_reg, ovf_flag_next;
`endif

    always_comb begin
        state_next     = state_reg;
        win_cnt_next   = win_cnt_reg;
        rc_tick_next   = 1'b0;
        rc_clr_next    = 1'b0;
        res_valid_next = 1'b0;
        result_next    = result_reg;
        ovf_next       = ovf_reg;
`ifdef RIPPLE_CHECK_EN
        shadow_next    = shadow_reg;
        err_next       = err_reg;
`else
        tick_lo_next   = tick_lo_reg;
        ovf_flag_next  = ovf_flag_reg;
`endif
        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    win_cnt_next = win_len;
                    rc_clr_next  = 1'b1;
                    state_next   = S_CLEAR;
`ifdef RIPPLE_CHECK_EN
                    shadow_next   = '0;
`else
                    tick_lo_next  = '0;
                    ovf_flag_next = 1'b0;
`endif
                end
            end
            S_CLEAR: begin
                if (win_cnt_reg != '0) begin
                    state_next = S_RUN;
                end else begin
                    state_next   = S_SETTLE;
                    win_cnt_next = SETTLE_LOAD;
                end
            end
            S_RUN: begin
                rc_tick_next = ev;
                if (ev) begin
`ifdef RIPPLE_CHECK_EN
                    if (shadow_reg != SHADOW_SAT)
                        shadow_next = shadow_reg + 1'b1;
`else
                    if (tick_lo_reg == '1)
                        ovf_flag_next = 1'b1;
                    tick_lo_next = tick_lo_reg + 1'b1;
`endif
                end
                if (win_cnt_reg == WIN_W'(1)) begin
                    state_next   = S_SETTLE;
                    win_cnt_next = SETTLE_LOAD;
                end else begin
                    win_cnt_next = win_cnt_reg - 1'b1;
                end
            end
            S_SETTLE: begin
                // Counts SETTLE..0, giving SETTLE+1 cycles for the ripple to resolve.
                if (win_cnt_reg == '0)
                    state_next = S_CAPTURE;
                else
                    win_cnt_next = win_cnt_reg - 1'b1;
            end
            S_CAPTURE: begin
                result_next = rc_q;
`ifdef RIPPLE_CHECK_EN
                ovf_next    = (shadow_reg >= SHADOW_SAT);
                err_next    = (rc_q != shadow_reg[N-1:0]);
`else
                ovf_next    = ovf_flag_reg;
`endif
                state_next  = S_HOLD;
            end
            S_HOLD: begin
                if (res_valid_reg && res_ready) begin
                    state_next = S_IDLE;
`ifdef RIPPLE_CHECK_EN
                    err_next   = 1'b0;
`endif
                end else begin
                    res_valid_next = 1'b1;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= S_IDLE;
            win_cnt_reg   <= '0;
            rc_tick_reg   <= 1'b0;
            rc_clr_reg    <= 1'b1;
            res_valid_reg <= 1'b0;
            result_reg    <= '0;
            ovf_reg       <= 1'b0;
`ifdef RIPPLE_CHECK_EN
            shadow_reg    <= '0;
            err_reg       <= 1'b0;
`else
            tick_lo_reg   <= '0;
            ovf_flag_reg  <= 1'b0;
`endif
        end else begin
            state_reg     <= state_next;
            win_cnt_reg   <= win_cnt_next;
            rc_tick_reg   <= rc_tick_next;
            rc_clr_reg    <= rc_clr_next;
            res_valid_reg <= res_valid_next;
            result_reg    <= result_next;
            ovf_reg       <= ovf_next;
`ifdef RIPPLE_CHECK_EN
            shadow_reg    <= shadow_next;
            err_reg       <= err_next;
`else
            tick_lo_reg   <= tick_lo_next;
            ovf_flag_reg  <= ovf_flag_next;
`endif
        end
    end

    assign rc_tick   = rc_tick_reg;
    assign rc_clr    = rc_clr_reg;
    assign busy      = (state_reg != S_IDLE);
    assign res_valid = res_valid_reg;
    assign result    = result_reg;
    assign ovf       = ovf_reg;
`ifdef RIPPLE_CHECK_EN
    assign err       = err_reg;
`endif

endmodule

// File: tb/tb_ripple_window_ctrl.sv
// Directed bench for ripple_window_ctrl with a behavioural ripple counter model on rc_tick/rc_clr.
module tb_ripple_window_ctrl;
    localparam int N      = 4;
    localparam int WIN_W  = 16;
    localparam int SETTLE = 2;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             start = 1'b0;
    logic [WIN_W-1:0] win_len = '0;
    logic             ev = 1'b0;
    logic [N-1:0]     rc_q;
    logic             rc_tick, rc_clr, busy, res_valid, ovf;
    logic             res_ready = 1'b0;
    logic [N-1:0]     result;
`ifdef RIPPLE_CHECK_EN
    logic             err;
`endif

    int passed = 0;
    int total  = 0;
    int tick_cnt = 0;
    int clr_cnt  = 0;
    int lat, t0, c0;
    logic [N-1:0] rc_cnt = '0;
    logic [N-1:0] rc_off = '0;

    ripple_window_ctrl #(.N(N), .WIN_W(WIN_W), .SETTLE(SETTLE)) dut (
        .clk(clk), .reset(reset), .start(start), .win_len(win_len), .ev(ev),
        .rc_q(rc_q), .rc_tick(rc_tick), .rc_clr(rc_clr), .busy(busy),
        .res_valid(res_valid), .res_ready(res_ready), .result(result), .ovf(ovf)
`ifdef RIPPLE_CHECK_EN
        , .err(err)
`endif
    );

    always #5 clk = ~clk;

    // Counter model: one count per clk cycle in which rc_tick is high, cleared by rc_clr.
    always @(negedge clk or posedge rc_clr) begin
        if (rc_clr) rc_cnt <= '0;
        else if (rc_tick === 1'b1) rc_cnt <= rc_cnt + 1'b1;
    end
    assign rc_q = rc_cnt + rc_off;

    always @(negedge clk) if (rc_tick === 1'b1) tick_cnt++;
    always @(posedge rc_clr) clr_cnt++;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Runs one measurement; lat = edges from start acceptance to res_valid.
    task automatic measure(input int w, input logic [31:0] pat, input logic ev_other,
                           input bit inject_start, output int lat_o);
        win_len = WIN_W'(w);
        start   = 1'b1;
        ev      = ev_other;
        step();
        lat_o = 0;
        start = 1'b0;
        chk("clear_cycle_rc_clr", rc_clr, 1);
        chk("clear_cycle_busy", busy, 1);
        step();
        lat_o++;
        for (int i = 0; i < w; i++) begin
            ev = pat[i];
            if (inject_start && i == 2) start = 1'b1;
            step();
            lat_o++;
            start = 1'b0;
        end
        ev = ev_other;
        while (res_valid !== 1'b1 && lat_o < 200) begin
            step();
            lat_o++;
        end
        ev = 1'b0;
    endtask

    task automatic take();
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        chk("hs_valid_drop", res_valid, 0);
        chk("hs_busy_drop", busy, 0);
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rc_clr", rc_clr, 1);
        chk("rst_rc_tick", rc_tick, 0);
        chk("rst_busy", busy, 0);
        chk("rst_valid", res_valid, 0);
        chk("rst_result", result, 0);
        chk("rst_ovf", ovf, 0);
        reset = 1'b1;
        step();
        chk("idle_rc_clr", rc_clr, 0);

        // win_len=8, five events
        t0 = tick_cnt; c0 = clr_cnt;
        measure(8, 32'b1010_1101, 1'b0, 1'b0, lat);
        chk("t1_latency", lat, 8 + SETTLE + 4);
        chk("t1_result", result, 5);
        chk("t1_ovf", ovf, 0);
        chk("t1_ticks", tick_cnt - t0, 5);
        chk("t1_clr_pulses", clr_cnt - c0, 1);
`ifdef RIPPLE_CHECK_EN
        chk("t1_err", err, 0);
`endif
        take();

        // win_len=0 with ev held high
        t0 = tick_cnt; c0 = clr_cnt;
        measure(0, 32'h0, 1'b1, 1'b0, lat);
        chk("t2_latency", lat, SETTLE + 4);
        chk("t2_result", result, 0);
        chk("t2_ovf", ovf, 0);
        chk("t2_ticks", tick_cnt - t0, 0);
        chk("t2_clr_pulses", clr_cnt - c0, 1);
        take();

        // Overflow: 20 ticks wrap to 4; hold with res_ready low
        t0 = tick_cnt;
        measure(20, 32'hFFFFFFFF, 1'b1, 1'b0, lat);
        chk("t3_latency", lat, 20 + SETTLE + 4);
        chk("t3_result", result, 4);
        chk("t3_ovf", ovf, 1);
        chk("t3_ticks", tick_cnt - t0, 20);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("t4_hold_valid", res_valid, 1);
            chk("t4_hold_result", result, 4);
            chk("t4_hold_ovf", ovf, 1);
        end
        take();

        // Second start during RUN is ignored
        measure(6, 32'h3F, 1'b0, 1'b1, lat);
        chk("t5_latency", lat, 6 + SETTLE + 4);
        chk("t5_result", result, 6);
        take();
        repeat (4) step();
        chk("t5_no_second_busy", busy, 0);
        chk("t5_no_second_valid", res_valid, 0);

        // Async reset mid-RUN aborts
        win_len = WIN_W'(10);
        start = 1'b1;
        ev = 1'b1;
        step();
        start = 1'b0;
        repeat (4) step();
        chk("t6_running", busy, 1);
        reset = 1'b0;
        #1;
        chk("t6_rc_clr", rc_clr, 1);
        chk("t6_busy", busy, 0);
        chk("t6_tick", rc_tick, 0);
        chk("t6_valid", res_valid, 0);
        step();
        ev = 1'b0;
        reset = 1'b1;
        step();
        chk("t6_clr_release", rc_clr, 0);
        repeat (15) step();
        chk("t6_no_result", res_valid, 0);
        measure(3, 32'h7, 1'b0, 1'b0, lat);
        chk("t6_restart_latency", lat, 3 + SETTLE + 4);
        chk("t6_restart_result", result, 3);
        chk("t6_restart_ovf", ovf, 0);
        take();

`ifdef RIPPLE_CHECK_EN
        // Counter forced off by one -> err flagged with the result
        rc_off = 4'd1;
        measure(4, 32'hF, 1'b0, 1'b0, lat);
        chk("t7_result", result, 5);
        chk("t7_err", err, 1);
        take();
        chk("t7_err_cleared", err, 0);
        rc_off = 4'd0;
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
